// File: rtl/debug_unit_ctrl.sv
// Debug controller: takes single-byte commands (step / run / halt / dump), gates the
// pipeline clock enable and streams debug-word dump frames into a TX byte FIFO.
module debug_unit_ctrl #(
  parameter int unsigned NUM_WORDS = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  ERR_BYTE  = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  input  logic        fifo_full,
  input  logic [31:0] dbg_word,
  input  logic        halt_in,
  output logic [7:0]  fifo_din,
  output logic        fifo_wr_en,
  output logic [5:0]  dbg_sel,
  output logic        pipe_en,
  output logic        busy,
  output logic        cmd_overrun
);

  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_RUN,
    S_SEL,
    S_SEND,
    S_ECHO
  } state_t;

  state_t      state_q, state_d;
  logic        rdy_prev_q;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] snap_q, snap_d;
  logic [5:0]  idx_q, idx_d;
  logic [1:0]  byte_q, byte_d;
  logic        sync_q, sync_d;
  logic        cnt_phase_q, cnt_phase_d;
  logic        ovr_q, ovr_d;
  logic        busy_q;
  logic        rise;
  logic        frame_start;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] b);
    return w[{b, 3'b000} +: 8];
  endfunction

  always_comb begin
    rise        = rx_data_rdy && !rdy_prev_q;
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    sync_d      = sync_q;
    cnt_phase_d = cnt_phase_q;
    snap_d      = snap_q;
    ovr_d       = ovr_q;
    frame_start = 1'b0;
    pipe_en     = 1'b0;
    fifo_wr_en  = 1'b0;
    fifo_din    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          if (rx_data == CMD_STEP)      state_d = S_STEP;
          else if (rx_data == CMD_RUN)  state_d = S_RUN;
          else if (rx_data == CMD_DUMP) frame_start = 1'b1;
          else                          state_d = S_ECHO;
        end
      end
      S_STEP: begin
        pipe_en     = 1'b1;
        frame_start = 1'b1;
      end
      S_RUN: begin
        // A halt wins over any byte arriving in the same cycle.
        if (halt_in || (rise && rx_data == CMD_HALT)) frame_start = 1'b1;
        else                                          pipe_en     = 1'b1;
      end
      S_SEL: begin
        if (sync_q) begin
          fifo_din = SYNC_BYTE;
          if (!fifo_full) begin
            fifo_wr_en = 1'b1;
            sync_d     = 1'b0;
            state_d    = S_SEND;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        fifo_din = cnt_phase_q ? byte_of(snap_q, byte_q) : byte_of(dbg_word, byte_q);
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          byte_d     = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            if (cnt_phase_q)            state_d     = S_IDLE;
            else if (idx_q == LAST_IDX) cnt_phase_d = 1'b1;
            else begin
              idx_d   = idx_q + 6'd1;
              state_d = S_SEL;
            end
          end
        end
      end
      S_ECHO: begin
        fifo_din = ERR_BYTE;
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cyc_d = cyc_q + {31'd0, pipe_en};

    // Snapshot includes this cycle's increment so a single step reports 1.
    if (frame_start) begin
      state_d     = S_SEL;
      idx_d       = 6'd0;
      byte_d      = 2'd0;
      sync_d      = 1'b1;
      cnt_phase_d = 1'b0;
      snap_d      = cyc_d;
    end

    if (rise && (state_q == S_STEP || state_q == S_SEL ||
                 state_q == S_SEND || state_q == S_ECHO)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rdy_prev_q  <= 1'b0;
      cyc_q       <= 32'd0;
      snap_q      <= 32'd0;
      idx_q       <= 6'd0;
      byte_q      <= 2'd0;
      sync_q      <= 1'b0;
      cnt_phase_q <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_prev_q  <= rx_data_rdy;
      cyc_q       <= cyc_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      sync_q      <= sync_d;
      cnt_phase_q <= cnt_phase_d;
      ovr_q       <= ovr_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign dbg_sel     = idx_q;
  assign busy        = busy_q;
  assign cmd_overrun = ovr_q;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Bench for debug_unit_ctrl: vector table plus randomized commands, frames checked
// against a byte-list model built from the command rules.
module tb_debug_unit_ctrl;

  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_data_rdy;
  logic        fifo_full = 1'b0;
  logic [31:0] dbg_word;
  logic        halt_in;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
  logic [5:0]  dbg_sel;
  logic        pipe_en;
  logic        busy;
  logic        cmd_overrun;

  always #5 clk = ~clk;

  debug_unit_ctrl #(.NUM_WORDS(NW), .SYNC_BYTE(8'hA5), .ERR_BYTE(8'h3F)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .fifo_full(fifo_full), .dbg_word(dbg_word), .halt_in(halt_in),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .dbg_sel(dbg_sel),
    .pipe_en(pipe_en), .busy(busy), .cmd_overrun(cmd_overrun)
  );

  logic [31:0] mem [64];
  always @(posedge clk) dbg_word <= mem[dbg_sel];

  int checks = 0;
  int failures = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int pipe_cnt = 0;
  int full_viol = 0;
  logic [31:0] exp_cnt;
  int cur_base;
  int stall_at = -1;
  bit rnd_full = 1'b0;
  bit manual_full = 1'b0;

  // Observe writes and enable away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (fifo_wr_en === 1'b1) begin
        cap_q.push_back(fifo_din);
        if (fifo_full) full_viol++;
      end
      if (pipe_en === 1'b1) pipe_cnt++;
    end
  end

  int stall_left = 0;
  int last_stall = -1;
  always @(posedge clk) begin
    #1;
    if (manual_full) fifo_full = 1'b1;
    else if (stall_left > 0) begin
      fifo_full = 1'b1;
      stall_left--;
    end else if (stall_at >= 0 && stall_at != last_stall && busy === 1'b1 &&
                 cap_q.size() == stall_at) begin
      last_stall = stall_at;
      fifo_full  = 1'b1;
      stall_left = 4;
    end else begin
      fifo_full = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_data_rdy = 1'b0;
    halt_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, " finished"}, {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  function automatic bit is_dump_cmd(input logic [7:0] c);
    return (c == 8'h53 || c == 8'h52 || c == 8'h44);
  endfunction

  // Expected frame: sync, each word little-endian, then the cycle count.
  task automatic build_exp(input logic [7:0] c);
    exp_q.delete();
    if (is_dump_cmd(c)) begin
      exp_q.push_back(8'hA5);
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < 4; b++) exp_q.push_back(8'((mem[w] >> (8 * b)) & 32'hFF));
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((exp_cnt >> (8 * b)) & 32'hFF));
    end else begin
      exp_q.push_back(8'h3F);
    end
  endtask

  task automatic cmp_frame(input string name, input int exp_len);
    chk({name, " len"}, cap_q.size() - cur_base, exp_len);
    for (int i = 0; i < exp_q.size(); i++)
      if (cur_base + i < cap_q.size())
        chk($sformatf("%s byte%0d", name, i), cap_q[cur_base + i], exp_q[i]);
  endtask

  task automatic run_vec(input logic [7:0] c, input int run_len, input int mode,
                         input int exp_pipe, input int exp_len, input string name);
    int pipe_base = pipe_cnt;
    int viol_base = full_viol;
    cur_base = cap_q.size();
    rx_data = c;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    if (c == 8'h53) exp_cnt += 32'd1;
    else if (c == 8'h52) begin
      for (int i = 0; i < run_len; i++) begin
        rx_data = 8'h5A;
        rx_data_rdy = (run_len >= 4 && i == 1);
        tick();
      end
      case (mode)
        0: halt_in = 1'b1;
        1: begin rx_data = 8'h48; rx_data_rdy = 1'b1; end
        default: begin rx_data = 8'h53; rx_data_rdy = 1'b1; halt_in = 1'b1; end
      endcase
      tick();
      halt_in = 1'b0;
      rx_data_rdy = 1'b0;
      exp_cnt += 32'(run_len);
    end
    wait_idle(name);
    build_exp(c);
    cmp_frame(name, exp_len);
    chk({name, " pipe_en cycles"}, pipe_cnt - pipe_base, exp_pipe);
    chk({name, " write while full"}, full_viol - viol_base, 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int run_len;
    int mode;
    int stall_off;
    int exp_pipe;
    int exp_len;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] golden[13];

  initial begin
    tbl[0] = '{8'h52, 10, 0, -1, 10, 13};
    tbl[1] = '{8'h44,  0, 0,  6,  0, 13};
    tbl[2] = '{8'h53,  0, 0,  2,  1, 13};
    tbl[3] = '{8'h52,  5, 1, -1,  5, 13};
    tbl[4] = '{8'h52,  3, 2,  9,  3, 13};
    tbl[5] = '{8'h58,  0, 0, -1,  0,  1};
    tbl[6] = '{8'h48,  0, 0, -1,  0,  1};
    tbl[7] = '{8'h44,  0, 0,  0,  0, 13};
    golden = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
               8'h01, 8'h00, 8'h00, 8'h00};
    foreach (mem[i]) mem[i] = 32'd0;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_data_rdy = 1'b0;
    halt_in = 1'b0;
    exp_cnt = 32'd0;

    tick();
    chk("reset fifo_din", fifo_din, 0);
    chk("reset fifo_wr_en", fifo_wr_en, 0);
    chk("reset dbg_sel", dbg_sel, 0);
    chk("reset pipe_en", pipe_en, 0);
    chk("reset busy", busy, 0);
    chk("reset cmd_overrun", cmd_overrun, 0);
    tick();
    rst = 1'b0;

    // Single step with known words.
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    run_vec(8'h53, 0, 0, 1, 13, "step known");
    for (int i = 0; i < 13; i++)
      if (cur_base + i < cap_q.size())
        chk($sformatf("step golden%0d", i), cap_q[cur_base + i], golden[i]);

    do_reset();
    for (int v = 0; v < 8; v++) begin
      mem[0] = $urandom;
      mem[1] = $urandom;
      stall_at = (tbl[v].stall_off >= 0) ? cap_q.size() + tbl[v].stall_off : -1;
      run_vec(tbl[v].cmd, tbl[v].run_len, tbl[v].mode, tbl[v].exp_pipe, tbl[v].exp_len,
              $sformatf("vec%0d", v));
      if (v == 0 && cur_base + 9 < cap_q.size())
        chk("run10 count byte0", cap_q[cur_base + 9], 8'h0A);
    end
    stall_at = -1;

    // Ready held high across a whole frame yields one frame only.
    mem[0] = $urandom;
    mem[1] = $urandom;
    cur_base = cap_q.size();
    rx_data = 8'h44;
    rx_data_rdy = 1'b1;
    repeat (20) tick();
    rx_data_rdy = 1'b0;
    wait_idle("held rdy");
    build_exp(8'h44);
    cmp_frame("held rdy", 13);
    chk("held rdy overrun", cmd_overrun, 0);

    // Command arriving during a stalled echo is dropped and flagged.
    manual_full = 1'b1;
    tick();
    tick();
    cur_base = cap_q.size();
    rx_data = 8'h58;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    tick();
    rx_data = 8'h51;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    manual_full = 1'b0;
    wait_idle("echo overrun");
    chk("echo overrun flag", cmd_overrun, 1);
    chk("echo overrun len", cap_q.size() - cur_base, 1);
    if (cap_q.size() > cur_base) chk("echo overrun byte", cap_q[cur_base], 8'h3F);
    repeat (5) tick();
    chk("overrun sticky", cmd_overrun, 1);

    // Reset in the middle of a dump aborts it.
    do_reset();
    mem[0] = $urandom;
    mem[1] = $urandom;
    cur_base = cap_q.size();
    rx_data = 8'h44;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    tick();
    rx_data = 8'h51;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    begin
      bit got = 1'b0;
      int n;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        #1;
        if (cap_q.size() >= cur_base + 3) begin
          got = 1'b1;
          break;
        end
      end
      chk("mid-send reached", {31'd0, got}, 32'd1);
      chk("mid-send overrun set", cmd_overrun, 1);
      rst = 1'b1;
      tick();
      chk("abort fifo_wr_en", fifo_wr_en, 0);
      chk("abort fifo_din", fifo_din, 0);
      chk("abort busy", busy, 0);
      chk("abort dbg_sel", dbg_sel, 0);
      chk("abort pipe_en", pipe_en, 0);
      chk("abort cmd_overrun", cmd_overrun, 0);
      n = cap_q.size();
      tick();
      rst = 1'b0;
      exp_cnt = 32'd0;
      repeat (20) tick();
      chk("abort no more bytes", cap_q.size(), n);
    end

    // Randomized commands with random FIFO back-pressure.
    rnd_full = 1'b1;
    for (int it = 0; it < 25; it++) begin
      logic [7:0] c;
      int sel;
      int rl;
      sel = $urandom_range(0, 4);
      rl = $urandom_range(1, 12);
      case (sel)
        0: c = 8'h53;
        1, 4: c = 8'h52;
        2: c = 8'h44;
        default: begin
          c = 8'($urandom_range(0, 255));
          if (is_dump_cmd(c)) c = 8'h58;
        end
      endcase
      mem[0] = $urandom;
      mem[1] = $urandom;
      run_vec(c, rl, $urandom_range(0, 2),
              (c == 8'h53) ? 1 : ((c == 8'h52) ? rl : 0),
              is_dump_cmd(c) ? 13 : 1, $sformatf("rnd%0d", it));
    end
    rnd_full = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
